// File: rtl/buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : buffer_pkg
// Brief  : Shared widths and arbiter state encoding for the packet buffer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package buffer_pkg;

  localparam int BUF_DATA_W  = 32;
  localparam int BUF_DEPTH_W = 14;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_GNT0 = 2'd1;
  localparam logic [1:0] c_ST_GNT1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = c_ST_IDLE,
    GNT0 = c_ST_GNT0,
    GNT1 = c_ST_GNT1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/buffer_write_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : buffer_write_arbiter_if
// Brief  : Source streams plus buffer write/snoop signals of the arbiter.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface buffer_write_arbiter_if #(
  parameter int DATA_W = buffer_pkg::BUF_DATA_W
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_last;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_last;
  logic              req1_ready;
  logic [DATA_W-1:0] buf_data_in;
  logic              buf_wr_en;
  logic              buf_rd_en;
  logic              buf_data_av;

  // Source/buffer side: drives the packet streams and the snooped read strobes.
  modport master (
    output req0_valid, req0_data, req0_last, input req0_ready,
    output req1_valid, req1_data, req1_last, input req1_ready,
    input  buf_data_in, buf_wr_en,
    output buf_rd_en, buf_data_av
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, output req0_ready,
    input  req1_valid, req1_data, req1_last, output req1_ready,
    output buf_data_in, buf_wr_en,
    input  buf_rd_en, buf_data_av
  );
endinterface
`default_nettype wire

// File: rtl/buffer_occupancy_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : buffer_occupancy_counter
// Brief  : Saturating up/down word count of the buffer with full flag.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module buffer_occupancy_counter
  import buffer_pkg::*;
#(
  parameter int DEPTH_W = BUF_DEPTH_W
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_inc,
  input  wire logic             i_dec,
  output logic      [DEPTH_W:0] o_count,
  output logic                  o_full
);
  localparam logic [DEPTH_W:0] c_CAPACITY = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0] c_ONE      = {{DEPTH_W{1'b0}}, 1'b1};

  logic [DEPTH_W:0] r_count;
  logic             w_up;
  logic             w_down;

  // Never count past capacity, never count a read from an empty buffer.
  assign w_up    = i_inc && (r_count != c_CAPACITY);
  assign w_down  = i_dec && (r_count != '0);
  assign o_count = r_count;
  assign o_full  = (r_count == c_CAPACITY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_up && !w_down) begin
      r_count <= r_count + c_ONE;
    end else if (w_down && !w_up) begin
      r_count <= r_count - c_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/buffer_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : buffer_write_arbiter
// Brief  : Round-robin whole-packet arbiter for the buffer write port.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module buffer_write_arbiter
  import buffer_pkg::*;
#(
  parameter int DATA_W        = BUF_DATA_W,
  parameter int DEPTH_W       = BUF_DEPTH_W,
  parameter int MAX_PKT_WORDS = 384
) (
  input  wire logic             clk,
  input  wire logic             reset,
  buffer_write_arbiter_if.slave bus,
  output logic      [DEPTH_W:0] occupancy,
  output logic                  pkt_done,
  output logic                  pkt_src,
  output logic      [DEPTH_W:0] pkt_len,
  output logic                  err_oversize
);
  localparam logic [DEPTH_W:0] c_CAPACITY = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0] c_MAX_PKT  = (DEPTH_W+1)'(MAX_PKT_WORDS);
  localparam logic [DEPTH_W:0] c_ONE      = {{DEPTH_W{1'b0}}, 1'b1};

  arb_state_t        r_state;
  logic              r_rr_ptr;
  logic [DEPTH_W:0]  r_word_cnt;
  logic [DATA_W-1:0] r_data_hold;
  logic              r_pkt_done;
  logic              r_pkt_src;
  logic [DEPTH_W:0]  r_pkt_len;
  logic              r_err;

  logic              w_full;
  logic              w_src;
  logic              w_beat;
  logic              w_last;
  logic              w_admit;
  logic [DATA_W-1:0] w_data;
  logic [DEPTH_W:0]  w_room;
  logic [DEPTH_W:0]  w_cnt_next;

  buffer_occupancy_counter #(.DEPTH_W(DEPTH_W)) u_occ (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_beat),
    .i_dec   (bus.buf_rd_en && bus.buf_data_av),
    .o_count (occupancy),
    .o_full  (w_full)
  );

  assign bus.req0_ready = (r_state == GNT0) && !w_full;
  assign bus.req1_ready = (r_state == GNT1) && !w_full;

  assign w_src      = (r_state == GNT1);
  assign w_beat     = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
  assign w_last     = w_src ? bus.req1_last : bus.req0_last;
  assign w_data     = w_src ? bus.req1_data : bus.req0_data;
  assign w_cnt_next = r_word_cnt + c_ONE;
  assign w_room     = c_CAPACITY - occupancy;
  assign w_admit    = (w_room >= c_MAX_PKT) && (bus.req0_valid || bus.req1_valid);

  // Data port shows the live word on a beat and otherwise holds the last one written.
  assign bus.buf_wr_en   = w_beat;
  assign bus.buf_data_in = w_beat ? w_data : r_data_hold;

  assign pkt_done     = r_pkt_done;
  assign pkt_src      = r_pkt_src;
  assign pkt_len      = r_pkt_len;
  assign err_oversize = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_word_cnt  <= '0;
      r_data_hold <= '0;
      r_pkt_done  <= 1'b0;
      r_pkt_src   <= 1'b0;
      r_pkt_len   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_beat) begin
        r_data_hold <= w_data;
        if (w_cnt_next > c_MAX_PKT) begin
          r_err <= 1'b1;
        end
      end
      case (r_state)
        IDLE: begin
          if (w_admit) begin
            if (bus.req0_valid && bus.req1_valid) begin
              r_state <= r_rr_ptr ? GNT1 : GNT0;
            end else if (bus.req0_valid) begin
              r_state <= GNT0;
            end else begin
              r_state <= GNT1;
            end
          end
        end
        GNT0, GNT1: begin
          if (w_beat) begin
            if (w_last) begin
              r_state    <= IDLE;
              r_rr_ptr   <= ~w_src;
              r_pkt_done <= 1'b1;
              r_pkt_src  <= w_src;
              r_pkt_len  <= w_cnt_next;
              r_word_cnt <= '0;
            end else begin
              r_word_cnt <= w_cnt_next;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_buffer_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_buffer_write_arbiter
// Brief  : Scoreboard bench for buffer_write_arbiter with directed packets.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_buffer_write_arbiter;
  localparam int DW      = 32;
  localparam int DEPTH_W = 14;
  localparam int MAXW    = 384;
  localparam int CAP     = 1 << DEPTH_W;

  typedef struct packed {
    logic             src;
    logic [DEPTH_W:0] len;
  } pkt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  buffer_write_arbiter_if #(.DATA_W(DW)) bus ();

  logic [DEPTH_W:0] occupancy;
  logic             pkt_done;
  logic             pkt_src;
  logic [DEPTH_W:0] pkt_len;
  logic             err_oversize;

  buffer_write_arbiter #(.DATA_W(DW), .DEPTH_W(DEPTH_W), .MAX_PKT_WORDS(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .occupancy    (occupancy),
    .pkt_done     (pkt_done),
    .pkt_src      (pkt_src),
    .pkt_len      (pkt_len),
    .err_oversize (err_oversize)
  );

  int          checks = 0;
  int          failures = 0;
  int          wr_seen = 0;
  logic [31:0] exp_wr_q[$];
  pkt_t        exp_pkt_q[$];
  int          wa, wb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every packet report is popped against the queues.
  always @(negedge clk) begin
    if (reset && bus.buf_wr_en) begin
      wr_seen++;
      if (exp_wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: actual=%0h expected=none", bus.buf_data_in);
      end else begin
        check("wr_data", {32'd0, bus.buf_data_in}, {32'd0, exp_wr_q.pop_front()});
      end
    end
    if (reset && pkt_done) begin
      if (exp_pkt_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL pkt_unexpected: actual src=%0d len=%0d expected=none", pkt_src, pkt_len);
      end else begin
        pkt_t e;
        e = exp_pkt_q.pop_front();
        check("pkt_src", 64'(pkt_src), 64'(e.src));
        check("pkt_len", 64'(pkt_len), 64'(e.len));
      end
    end
  end

  task automatic drive(input bit s, input bit v, input logic [31:0] d, input bit l);
    if (s) begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end else begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end
  endtask

  // Present one word, wait (bounded) for ready, return just after the beat edge.
  task automatic send_word(input bit s, input logic [31:0] d, input bit l, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    drive(s, 1'b1, d, l);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (s ? bus.req1_ready : bus.req0_ready) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: src=%0d actual=no_ready expected=ready", s);
    end
    @(posedge clk); #1;
    drive(s, 1'b0, '0, 1'b0);
  endtask

  task automatic send_pkt(input bit s, input int n, input logic [31:0] base);
    int w;
    exp_pkt_q.push_back('{src: s, len: (DEPTH_W+1)'(n)});
    for (int i = 0; i < n; i++) begin
      exp_wr_q.push_back(base + 32'(i));
      send_word(s, base + 32'(i), (i == n - 1), w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.req0_valid = 0; bus.req0_data = '0; bus.req0_last = 0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.req1_last = 0;
    bus.buf_rd_en = 0; bus.buf_data_av = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_outputs", {59'd0, pkt_done, pkt_src, err_oversize, bus.buf_wr_en, bus.req0_ready},
          64'd0);
    check("rst_len_data", {pkt_len, bus.buf_data_in}, 64'd0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;

    // 1: three-word packet from source 0, one bubble before the grant
    cnt = wr_seen;
    exp_pkt_q.push_back('{src: 1'b0, len: 15'd3});
    exp_wr_q.push_back(32'hAAAA_0001);
    exp_wr_q.push_back(32'hAAAA_0002);
    exp_wr_q.push_back(32'hAAAA_0003);
    send_word(0, 32'hAAAA_0001, 0, wa);
    check("t1_bubble", 64'(wa), 64'd1);
    send_word(0, 32'hAAAA_0002, 0, wa);
    check("t1_no_stall", 64'(wa), 64'd0);
    send_word(0, 32'hAAAA_0003, 1, wa);
    @(negedge clk);
    check("t1_pkt_done", 64'(pkt_done), 64'd1);
    check("t1_writes", 64'(wr_seen - cnt), 64'd3);
    check("t1_occupancy", 64'(occupancy), 64'd3);

    // 2: both sources busy, grants alternate starting with source 1 (rr_ptr=1)
    exp_wr_q.push_back(32'hB100_0000); exp_wr_q.push_back(32'hB100_0001);
    exp_wr_q.push_back(32'hB000_0000); exp_wr_q.push_back(32'hB000_0001);
    exp_wr_q.push_back(32'hB100_0010); exp_wr_q.push_back(32'hB100_0011);
    exp_wr_q.push_back(32'hB000_0010); exp_wr_q.push_back(32'hB000_0011);
    exp_pkt_q.push_back('{src: 1'b1, len: 15'd2});
    exp_pkt_q.push_back('{src: 1'b0, len: 15'd2});
    exp_pkt_q.push_back('{src: 1'b1, len: 15'd2});
    exp_pkt_q.push_back('{src: 1'b0, len: 15'd2});
    @(posedge clk); #1;
    fork
      begin
        send_word(0, 32'hB000_0000, 0, wa); send_word(0, 32'hB000_0001, 1, wa);
        send_word(0, 32'hB000_0010, 0, wa); send_word(0, 32'hB000_0011, 1, wa);
      end
      begin
        send_word(1, 32'hB100_0000, 0, wb); send_word(1, 32'hB100_0001, 1, wb);
        send_word(1, 32'hB100_0010, 0, wb); send_word(1, 32'hB100_0011, 1, wb);
      end
    join
    @(negedge clk);
    check("t2_occupancy", 64'(occupancy), 64'd11);

    // 5: oversize packet of MAXW+1 words
    exp_pkt_q.push_back('{src: 1'b0, len: 15'(MAXW + 1)});
    for (int i = 0; i <= MAXW; i++) begin
      exp_wr_q.push_back(32'hD000_0000 + 32'(i));
      send_word(0, 32'hD000_0000 + 32'(i), (i == MAXW), wa);
      if (i == MAXW - 1) check("t5_err_before", 64'(err_oversize), 64'd0);
      if (i == MAXW)     check("t5_err_after", 64'(err_oversize), 64'd1);
    end
    @(negedge clk);
    check("t5_occupancy", 64'(occupancy), 64'd396);

    // Fill to one word above the admission threshold
    for (int p = 0; p < 52; p++) send_pkt(0, 300, 32'h1000_0000 + 32'(p << 12));
    send_pkt(0, 5, 32'h2000_0000);
    @(negedge clk);
    check("fill_occupancy", 64'(occupancy), 64'(CAP - MAXW + 1));

    // 3: no admission until one snooped read frees a word
    exp_pkt_q.push_back('{src: 1'b1, len: 15'd386});
    exp_wr_q.push_back(32'hC000_0000);
    @(posedge clk); #1;
    drive(1, 1'b1, 32'hC000_0000, 1'b0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.req1_ready || bus.buf_wr_en) cnt++;
    end
    check("t3_no_admit", 64'(cnt), 64'd0);
    @(posedge clk); #1; bus.buf_rd_en = 1; bus.buf_data_av = 1;
    @(posedge clk); #1; bus.buf_rd_en = 0; bus.buf_data_av = 0;
    @(negedge clk);
    check("t3_occ_after_read", 64'(occupancy), 64'(CAP - MAXW));
    check("t3_still_idle", 64'(bus.req1_ready), 64'd0);
    @(negedge clk);
    check("t3_grant", 64'(bus.req1_ready), 64'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, 1'b0);

    // 4: buffer fills mid-packet, ready drops until a read
    for (int i = 1; i < MAXW; i++) begin
      exp_wr_q.push_back(32'hC000_0000 + 32'(i));
      send_word(1, 32'hC000_0000 + 32'(i), 0, wa);
    end
    exp_wr_q.push_back(32'hC000_0180);
    drive(1, 1'b1, 32'hC000_0180, 1'b0);
    @(negedge clk);
    check("t4_occ_full", 64'(occupancy), 64'(CAP));
    cnt = 0;
    repeat (3) begin
      if (bus.req1_ready || bus.buf_wr_en) cnt++;
      @(negedge clk);
    end
    check("t4_ready_low_full", 64'(cnt), 64'd0);
    @(posedge clk); #1; bus.buf_rd_en = 1; bus.buf_data_av = 1;
    @(posedge clk); #1; bus.buf_rd_en = 0; bus.buf_data_av = 0;
    @(negedge clk);
    check("t4_ready_after_read", 64'(bus.req1_ready), 64'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, 1'b0);
    bus.buf_rd_en = 1; bus.buf_data_av = 1;
    exp_wr_q.push_back(32'hC000_0181);
    send_word(1, 32'hC000_0181, 1, wa);
    bus.buf_rd_en = 0; bus.buf_data_av = 0;
    check("t4_full_wait", 64'(wa), 64'd1);
    @(negedge clk);
    check("t4_rw_same_cycle", 64'(occupancy), 64'(CAP - 1));

    // Drain below the threshold, then a single-word packet (leaves rr_ptr=1)
    @(posedge clk); #1; bus.buf_rd_en = 1; bus.buf_data_av = 1;
    repeat (400) @(posedge clk);
    #1; bus.buf_rd_en = 0; bus.buf_data_av = 0;
    @(negedge clk);
    check("drain_occupancy", 64'(occupancy), 64'(CAP - 1 - 400));
    @(posedge clk); #1;
    send_pkt(0, 1, 32'hE000_0000);

    // 6: reset during word 3 of a 5-word packet
    exp_wr_q.push_back(32'hF000_0000);
    exp_wr_q.push_back(32'hF000_0001);
    send_word(1, 32'hF000_0000, 0, wa);
    send_word(1, 32'hF000_0001, 0, wa);
    drive(1, 1'b1, 32'hF000_0002, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_ctrl", {59'd0, bus.buf_wr_en, bus.req1_ready, bus.req0_ready, pkt_done,
          err_oversize}, 64'd0);
    check("t6_rst_occupancy", 64'(occupancy), 64'd0);
    check("t6_rst_data", 64'(bus.buf_data_in), 64'd0);
    drive(1, 1'b0, '0, 1'b0);
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    exp_wr_q.push_back(32'h6000_0000);
    exp_wr_q.push_back(32'h6100_0000);
    exp_pkt_q.push_back('{src: 1'b0, len: 15'd1});
    exp_pkt_q.push_back('{src: 1'b1, len: 15'd1});
    fork
      send_word(0, 32'h6000_0000, 1, wa);
      send_word(1, 32'h6100_0000, 1, wb);
    join
    @(negedge clk);
    check("t6_occupancy", 64'(occupancy), 64'd2);
    repeat (3) @(negedge clk);
    check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    check("pkt_queue_empty", 64'(exp_pkt_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
